// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - push-button to SR latch command sequencer with debounce and queueing
module sr_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int PULSE_LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic S,
    output logic R,
    output logic EN,
    output logic busy,
    output logic conflict
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    // Index 0 carries the set button, index 1 the reset button.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    db;
    logic [1:0]    db_q;
    logic [CW-1:0] cnt [2];

    logic req_set;
    logic req_rst;
    logic single;

    state_t        state_q, state_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          en_q, en_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          pend_v_q, pend_v_d;
    logic          pend_set_q, pend_set_d;

    assign btn = {btn_rst, btn_set};

    // Synchronise both buttons and debounce: a level change is accepted only after
    // DB_CYCLES consecutive synchronised samples disagree with the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_q  <= '0;
            cnt   <= '{default: '0};
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    db[i]  <= ~db[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press detection: only rising debounced levels produce requests.
    assign req_set  = db[0] & ~db_q[0];
    assign req_rst  = db[1] & ~db_q[1];
    assign single   = req_set ^ req_rst;
    assign conflict = req_set & req_rst;

    // State, registered latch outputs, strobe counter and pending slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            en_q       <= 1'b0;
            pcnt_q     <= '0;
            pend_v_q   <= 1'b0;
            pend_set_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            r_q        <= r_d;
            en_q       <= en_d;
            pcnt_q     <= pcnt_d;
            pend_v_q   <= pend_v_d;
            pend_set_q <= pend_set_d;
        end
    end

    // Next-state logic: S/R are launched one cycle before EN rises and held one
    // cycle after it falls, so the latch data is stable around the strobe.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        r_d        = r_q;
        en_d       = 1'b0;
        pcnt_d     = pcnt_q;
        pend_v_d   = pend_v_q;
        pend_set_d = pend_set_q;
        case (state_q)
            IDLE: begin
                if (pend_v_q) begin
                    state_d  = SETUP;
                    s_d      = pend_set_q;
                    r_d      = ~pend_set_q;
                    // A fresh press arriving as the slot drains refills it.
                    pend_v_d = single;
                    if (single) begin
                        pend_set_d = req_set;
                    end
                end else if (single) begin
                    state_d = SETUP;
                    s_d     = req_set;
                    r_d     = req_rst;
                end
            end
            SETUP: begin
                state_d = STROBE;
                en_d    = 1'b1;
                pcnt_d  = '0;
            end
            STROBE: begin
                if (pcnt_q == PW'(PULSE_LEN - 1)) begin
                    state_d = HOLD;
                end else begin
                    en_d   = 1'b1;
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            HOLD: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase
        if ((state_q != IDLE) && single) begin
            pend_v_d   = 1'b1;
            pend_set_d = req_set;
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign EN   = en_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - self-checking bench for sr_cmd_gen
module tb_sr_cmd_gen;

    localparam int DB = 4;
    localparam int PL = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_rst = 1'b0;
    logic S, R, EN, busy, conflict;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
        .S(S), .R(R), .EN(EN), .busy(busy), .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw sample history, window-based debounce, timeline sequencer.
    bit h_s[$];
    bit h_r[$];
    bit m_db_s, m_db_r, m_req_s, m_req_r;
    bit m_act, m_cmd_set, m_pv, m_pset;
    int m_t;
    bit m_single, m_ns, m_nr;

    function automatic bit all_differ(input bit h[$], input bit lvl);
        for (int i = 1; i <= DB; i++) if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        h_s.delete();
        h_r.delete();
        repeat (DB + 2) begin
            h_s.push_back(1'b0);
            h_r.push_back(1'b0);
        end
        m_db_s = 0; m_db_r = 0; m_req_s = 0; m_req_r = 0;
        m_act = 0; m_cmd_set = 0; m_pv = 0; m_pset = 0; m_t = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_single = m_req_s ^ m_req_r;
            if (m_act) begin
                if (m_single) begin m_pv = 1; m_pset = m_req_s; end
                if (m_t == PL + 1) m_act = 0;
                else m_t++;
            end else if (m_pv) begin
                m_act = 1; m_t = 0; m_cmd_set = m_pset;
                m_pv = m_single;
                if (m_single) m_pset = m_req_s;
            end else if (m_single) begin
                m_act = 1; m_t = 0; m_cmd_set = m_req_s;
            end
            m_ns = all_differ(h_s, m_db_s) ? ~m_db_s : m_db_s;
            m_nr = all_differ(h_r, m_db_r) ? ~m_db_r : m_db_r;
            m_req_s = m_ns & ~m_db_s;
            m_req_r = m_nr & ~m_db_r;
            m_db_s = m_ns;
            m_db_r = m_nr;
            h_s.push_front(btn_set); void'(h_s.pop_back());
            h_r.push_front(btn_rst); void'(h_r.pop_back());
        end
    end

    // Per-cycle comparison against the model plus latch-safety invariants.
    bit p_en, p_s, p_r;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_en = 0;
        end else if (model_on) begin
            chk("model_S", S, m_act & m_cmd_set);
            chk("model_R", R, m_act & ~m_cmd_set);
            chk("model_EN", EN, m_act && m_t >= 1 && m_t <= PL);
            chk("model_busy", busy, m_act);
            chk("model_conflict", conflict, m_req_s & m_req_r);
            chk("s_and_r", S & R, 0);
            if (EN && p_en) chk("sr_stable_en", {S, R}, {p_s, p_r});
            p_en = EN; p_s = S; p_r = R;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic do_reset(input bit bs, input bit br);
        btn_set = bs; btn_rst = br; rst_n = 0;
        cyc(2);
        chk("reset_outputs", {S, R, EN, busy, conflict}, 0);
        rst_n = 1;
    endtask

    typedef struct {
        bit rst_first; bit bs; bit br;
        bit es; bit er; bit een; bit eb; bit ecf;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input int n, input bit rf, input bit bs, input bit br,
                       input bit es, input bit er, input bit een, input bit eb, input bit ecf);
        vec_t v;
        v = '{rst_first: rf, bs: bs, br: br, es: es, er: er, een: een, eb: eb, ecf: ecf};
        for (int i = 0; i < n; i++) begin
            tbl.push_back(v);
            v.rst_first = 0;
        end
    endtask

    bit seen;
    int s_rises, en_cnt;
    bit prev_s;
    logic [19:0] tr_s, tr_r, tr_en, ex_s, ex_r, ex_en;

    initial begin
        m_reset();
        model_on = 1;

        // Reset with buttons held high, then release with buttons low.
        btn_set = 1; btn_rst = 1; rst_n = 0;
        cyc(3);
        chk("t1_reset_all_zero", {S, R, EN, busy, conflict}, 0);
        btn_set = 0; btn_rst = 0; rst_n = 1;
        seen = 0;
        repeat (10) begin cyc(); seen |= EN | busy; end
        chk("t1_idle_after_release", seen, 0);

        // Set press timeline (edges 1..12), then simultaneous press timeline.
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(5, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 0, 1, 0);
        add(2, 0, 1, 0, 1, 0, 1, 1, 0);
        add(1, 0, 1, 0, 1, 0, 0, 1, 0);
        add(2, 0, 1, 0, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(4, 0, 1, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0, 0, 1);
        add(2, 0, 1, 1, 0, 0, 0, 0, 0);
        add(6, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset(tbl[i].bs, tbl[i].br);
            btn_set = tbl[i].bs; btn_rst = tbl[i].br;
            cyc();
            chk($sformatf("vec%0d", i), {S, R, EN, busy, conflict},
                {tbl[i].es, tbl[i].er, tbl[i].een, tbl[i].eb, tbl[i].ecf});
        end

        // Bounce: toggling every 2 cycles never debounces; a clean press does once.
        do_reset(0, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            btn_set = ((i / 2) % 2) == 0;
            cyc();
            seen |= S | EN | busy;
        end
        btn_set = 0;
        repeat (8) begin cyc(); seen |= S | EN | busy; end
        chk("t3_bounce_quiet", seen, 0);
        s_rises = 0; en_cnt = 0; prev_s = S;
        btn_set = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) btn_set = 0;
            cyc();
            if (S && !prev_s) s_rises++;
            if (EN) en_cnt++;
            prev_s = S;
        end
        chk("t3_one_sequence", s_rises, 1);
        chk("t3_en_cycles", en_cnt, PL);

        // Reset press debounced during set's strobe is queued behind it.
        do_reset(0, 0);
        btn_set = 1;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) btn_rst = 1;
            cyc();
            tr_s[e-1] = S; tr_r[e-1] = R; tr_en[e-1] = EN;
            ex_s[e-1] = (e >= 7 && e <= 10);
            ex_r[e-1] = (e >= 12 && e <= 15);
            ex_en[e-1] = (e == 8 || e == 9 || e == 13 || e == 14);
        end
        chk("t5_s_trace", tr_s, ex_s);
        chk("t5_r_trace", tr_r, ex_r);
        chk("t5_en_trace", tr_en, ex_en);
        btn_set = 0; btn_rst = 0;
        cyc(10);

        // Reset mid-strobe drops outputs without a clock; held button re-debounces.
        do_reset(0, 0);
        btn_set = 1;
        cyc(8);
        chk("t6_in_strobe", {S, EN, busy}, 3'b111);
        #1 rst_n = 0;
        #1 chk("t6_async_drop", {S, R, EN, busy}, 0);
        cyc();
        rst_n = 1;
        seen = 0;
        repeat (6) begin cyc(); seen |= S | busy; end
        chk("t6_redebounce_quiet", seen, 0);
        cyc();
        chk("t6_cmd_after_redebounce", {S, busy}, 2'b11);
        btn_set = 0;
        cyc(10);

        // Randomised button activity checked against the model every cycle.
        for (int i = 0; i < 200; i++) begin
            btn_set = $urandom_range(0, 1);
            btn_rst = $urandom_range(0, 1);
            cyc($urandom_range(1, 12));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
